instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch: single-outstanding instruction fetch with redirect,    |
// | flush of in-flight requests and a sticky memory-timeout fault.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module instr_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        misalign,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LAST = 8'(IMEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    FLUSH = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] target, target_next;
  logic [7:0]  wait_cnt;
  logic [31:0] redirect_aligned;
  logic        take_redirect;
  logic        capture;
  logic        accept;
  logic        timeout;
  logic        wait_inc;
  logic        wait_clr;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign imem_addr        = pc;

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    target_next   = target;
    imem_req      = 1'b0;
    take_redirect = 1'b0;
    capture       = 1'b0;
    accept        = 1'b0;
    timeout       = 1'b0;
    wait_inc      = 1'b0;
    wait_clr      = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) begin
          take_redirect = 1'b1;
          pc_next       = redirect_aligned;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          wait_clr = 1'b1;
          if (redirect) begin
            take_redirect = 1'b1;
            pc_next       = redirect_aligned;
          end else begin
            capture    = 1'b1;
            pc_next    = pc + 32'd4;
            state_next = HOLD;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FAULT;
        end else begin
          wait_inc = 1'b1;
          if (redirect) begin
            // The request stays on the bus until acked, so the target waits.
            take_redirect = 1'b1;
            target_next   = redirect_aligned;
            state_next    = FLUSH;
          end
        end
      end
      FLUSH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          wait_clr   = 1'b1;
          state_next = FETCH;
          pc_next    = target;
          if (redirect) begin
            take_redirect = 1'b1;
            pc_next       = redirect_aligned;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = FAULT;
        end else begin
          wait_inc = 1'b1;
          if (redirect) begin
            take_redirect = 1'b1;
            target_next   = redirect_aligned;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          take_redirect = 1'b1;
          pc_next       = redirect_aligned;
          state_next    = FETCH;
        end else if (inst_ready) begin
          accept     = 1'b1;
          state_next = FETCH;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      target      <= 32'h0000_0000;
      wait_cnt    <= 8'd0;
      inst_valid  <= 1'b0;
      inst_out    <= NOP;
      pc_out      <= 32'h0000_0000;
      misalign    <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      target   <= target_next;
      misalign <= take_redirect && (redirect_pc[1:0] != 2'b00);
      if (wait_clr) begin
        wait_cnt <= 8'd0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout) begin
        fetch_fault <= 1'b1;
      end
      if (capture) begin
        inst_out   <= imem_rdata;
        pc_out     <= pc;
        inst_valid <= 1'b1;
      end else if (accept || take_redirect) begin
        inst_valid <= 1'b0;
      end
      if (accept) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// Self-checking bench for instr_fetch: scoreboard of acked words versus
// delivered instructions, plus redirect, stall, timeout and wrap scenarios.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack, redirect, inst_ready, inst_valid, misalign, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_out, pc_out, fetch_count;

  logic        imem_req_w, imem_ack_w, redirect_w, inst_ready_w, inst_valid_w, misalign_w, fetch_fault_w;
  logic [31:0] imem_addr_w, imem_rdata_w, redirect_pc_w, inst_out_w, pc_out_w, fetch_count_w;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_ready(inst_ready), .inst_valid(inst_valid),
    .inst_out(inst_out), .pc_out(pc_out), .misalign(misalign),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .inst_ready(inst_ready_w), .inst_valid(inst_valid_w),
    .inst_out(inst_out_w), .pc_out(pc_out_w), .misalign(misalign_w),
    .fetch_fault(fetch_fault_w), .fetch_count(fetch_count_w)
  );

  function automatic logic [31:0] data_for(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b0;
    imem_ack_w = 1'b0; imem_rdata_w = 32'h0; redirect_w = 1'b0;
    redirect_pc_w = 32'h0; inst_ready_w = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Ack the current request with the model word and record what should come out.
  task automatic ack_push(input logic [31:0] a);
    imem_ack = 1'b1; imem_rdata = data_for(a);
    e.pc = a; e.inst = data_for(a);
    sb.push_back(e);
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
    vectors++; if (inst_out !== 32'h13) begin miscompares++; $display("FAIL rst_inst: got %h want 00000013", inst_out); end
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
    vectors++; if ({misalign, fetch_fault} !== 2'b00) begin miscompares++; $display("FAIL rst_flags: got %b want 00", {misalign, fetch_fault}); end
    vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL rst_count: got %h want 0", fetch_count); end
    vectors++; if (imem_addr_w !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL rst_addr_w: got %h want fffffffc", imem_addr_w); end
    rst = 1'b0;
    tick();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL idle_to_fetch: got %b want 1", imem_req); end
  endtask

  task automatic test_basic();
    bit ok;
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    exp_count = 32'h0;
    for (int i = 0; i < 3; i++) begin
      wait_req(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL basic_req_wait: got timeout want req"); end
      vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL basic_addr: got %h want %h", imem_addr, exp_pc); end
      tick();
      vectors++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin miscompares++; $display("FAIL basic_stable: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
      ack_push(exp_pc);
      vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %b want 1", inst_valid); end
      if (inst_valid === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++; if ({pc_out, inst_out} !== {e.pc, e.inst}) begin miscompares++; $display("FAIL basic_sb: got %h/%h want %h/%h", pc_out, inst_out, e.pc, e.inst); end
        exp_count++;
      end
      exp_pc += 32'd4;
      tick();
    end
    vectors++; if (fetch_count !== exp_count || exp_count !== 32'd3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    logic [31:0] held_inst, held_pc;
    inst_ready = 1'b0;
    vectors++; if (imem_addr !== exp_pc) begin miscompares++; $display("FAIL stall_addr: got %h want %h", imem_addr, exp_pc); end
    ack_push(exp_pc);
    e = sb.pop_front();
    vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, e.pc, e.inst}) begin miscompares++; $display("FAIL stall_sb: got %b/%h/%h want 1/%h/%h", inst_valid, pc_out, inst_out, e.pc, e.inst); end
    held_inst = e.inst;
    held_pc   = e.pc;
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 2); imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      vectors++; if ({inst_valid, imem_req, inst_out, pc_out} !== {2'b10, held_inst, held_pc}) begin miscompares++; $display("FAIL stall_hold%0d: got %b%b/%h/%h want 10/%h/%h", i, inst_valid, imem_req, inst_out, pc_out, held_inst, held_pc); end
    end
    inst_ready = 1'b1;
    exp_count++;
    exp_pc += 32'd4;
    tick();
    inst_ready = 1'b0;
    vectors++; if (fetch_count !== exp_count) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", fetch_count, exp_count); end
  endtask

  task automatic test_redirect();
    // Redirect with the request still pending: old address held, data dropped.
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    vectors++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin miscompares++; $display("FAIL flush_hold: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_ack = 1'b0;
    vectors++; if ({inst_valid, imem_req, imem_addr} !== {2'b01, 32'h100}) begin miscompares++; $display("FAIL flush_target: got %b%b/%h want 01/00000100", inst_valid, imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h300; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    redirect = 1'b0; imem_ack = 1'b0;
    vectors++; if ({inst_valid, imem_addr} !== {1'b0, 32'h300}) begin miscompares++; $display("FAIL redir_with_ack: got %b/%h want 0/00000300", inst_valid, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_pc = 32'h500;
    tick();
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_ack = 1'b0;
    vectors++; if ({inst_valid, imem_addr} !== {1'b0, 32'h500}) begin miscompares++; $display("FAIL flush_overwrite: got %b/%h want 0/00000500", inst_valid, imem_addr); end
    ack_push(32'h500);
    vectors++; if (sb.size() !== 1 || inst_valid !== 1'b1) begin miscompares++; $display("FAIL redir_sb_depth: got %0d/%b want 1/1", sb.size(), inst_valid); end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++; if ({pc_out, inst_out} !== {e.pc, e.inst}) begin miscompares++; $display("FAIL redir_sb: got %h/%h want %h/%h", pc_out, inst_out, e.pc, e.inst); end
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
    vectors++; if ({misalign, inst_valid, imem_addr} !== {2'b10, 32'h100}) begin miscompares++; $display("FAIL misalign_pulse: got %b%b/%h want 10/00000100", misalign, inst_valid, imem_addr); end
    vectors++; if (fetch_count !== exp_count) begin miscompares++; $display("FAIL misalign_count: got %0d want %0d", fetch_count, exp_count); end
    tick();
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear: got %b want 0", misalign); end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    tick();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_req: got %b want 0", imem_req); end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0004; redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    vectors++; if ({inst_valid, misalign, imem_req, imem_addr} !== {3'b011, 32'h40}) begin miscompares++; $display("FAIL rstmid_idle_redir: got %b%b%b/%h want 011/00000040", inst_valid, misalign, imem_req, imem_addr); end
    vectors++; if (fetch_count !== 32'h0) begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", fetch_count); end
  endtask

  task automatic test_timeout();
    apply_reset();
    rst = 1'b0;
    tick();
    repeat (15) tick();
    vectors++; if ({fetch_fault, imem_req} !== 2'b01) begin miscompares++; $display("FAIL timeout_early: got %b%b want 01", fetch_fault, imem_req); end
    tick();
    vectors++; if ({fetch_fault, imem_req, inst_valid} !== 3'b100) begin miscompares++; $display("FAIL timeout_fault: got %b%b%b want 100", fetch_fault, imem_req, inst_valid); end
    imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    repeat (3) tick();
    imem_ack = 1'b0; redirect = 1'b0;
    vectors++; if ({fetch_fault, imem_req, inst_valid} !== 3'b100) begin miscompares++; $display("FAIL fault_sticky: got %b%b%b want 100", fetch_fault, imem_req, inst_valid); end
    rst = 1'b1;
    tick();
    vectors++; if (fetch_fault !== 1'b0) begin miscompares++; $display("FAIL fault_rst: got %b want 0", fetch_fault); end
  endtask

  task automatic test_wrap();
    apply_reset();
    rst = 1'b0;
    tick();
    vectors++; if ({imem_req_w, imem_addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin miscompares++; $display("FAIL wrap_first: got %b/%h want 1/fffffffc", imem_req_w, imem_addr_w); end
    imem_ack_w = 1'b1; imem_rdata_w = data_for(32'hFFFF_FFFC);
    e.pc = 32'hFFFF_FFFC; e.inst = data_for(32'hFFFF_FFFC);
    sb.push_back(e);
    tick();
    imem_ack_w = 1'b0;
    e = sb.pop_front();
    vectors++; if ({inst_valid_w, pc_out_w, inst_out_w} !== {1'b1, e.pc, e.inst}) begin miscompares++; $display("FAIL wrap_sb: got %b/%h/%h want 1/%h/%h", inst_valid_w, pc_out_w, inst_out_w, e.pc, e.inst); end
    inst_ready_w = 1'b1;
    tick();
    inst_ready_w = 1'b0;
    vectors++; if ({imem_req_w, imem_addr_w, fetch_count_w} !== {1'b1, 32'h0, 32'd1}) begin miscompares++; $display("FAIL wrap_addr: got %b/%h/%0d want 1/00000000/1", imem_req_w, imem_addr_w, fetch_count_w); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_misalign();
    test_rst_mid();
    test_timeout();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got hang want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
